control_sequencer: RTL and testbench

Instruction sequencer that drives the accumulator datapath. It fetches 20-bit instructions from a synchronous-read program ROM and decodes them into one-cycle ctl_* strobes plus a 16-bit arg. It keeps a zero flag captured from the datapath's is_zero. It executes loads, stores, ALU ops, and conditional/unconditional jumps until HALT.

---
 rtl/control_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Accumulator-machine instruction sequencer: fetch/decode/exec/mem FSM with zero flag.
// Optional single-step gating when STEP_EN is defined (adds the step input and a WAIT state).
module control_sequencer #(
  parameter int          PROG_AW  = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef STEP_EN
  input  logic               step,
`endif
  output logic [PROG_AW-1:0] prog_addr,
  input  logic [19:0]        prog_data,
  output logic [15:0]        arg,
  output logic               ctl_arg,
  output logic               ctl_nad,
  output logic               ctl_shl,
  output logic               ctl_shr,
  output logic               ctl_read,
  output logic               ctl_write,
  output logic               ctl_acc,
  input  logic               is_zero,
  output logic               halted,
  output logic               busy
);

  localparam logic [PROG_AW-1:0] RST_PC = PROG_AW'(RESET_PC);
  localparam logic [PROG_AW-1:0] ONE    = PROG_AW'(1);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_NAND = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JNZ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_WAIT
  } state_t;

`ifdef STEP_EN
  localparam state_t S_NEXT = S_WAIT;
`else
  localparam state_t S_NEXT = S_FETCH;
`endif

  state_t             state;
  state_t             state_nx;
  logic [PROG_AW-1:0] pc;
  logic [PROG_AW-1:0] pc_nx;
  logic [19:0]        ir;
  logic [19:0]        ir_nx;
  logic               zf;
  logic               zf_nx;
  logic [3:0]         op;
  logic [PROG_AW-1:0] tgt;
  logic [PROG_AW-1:0] pc_inc;

  assign op        = ir[19:16];
  assign tgt       = ir[PROG_AW-1:0];
  assign pc_inc    = pc + ONE;
  assign prog_addr = pc;
  assign halted    = (state == S_HALT);
  assign busy      = (state == S_FETCH) || (state == S_DECODE)
                  || (state == S_EXEC)  || (state == S_MEM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= RST_PC;
      ir    <= '0;
      zf    <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      zf    <= zf_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_nx     = ir;
    zf_nx     = zf;
    arg       = '0;
    ctl_arg   = 1'b0;
    ctl_nad   = 1'b0;
    ctl_shl   = 1'b0;
    ctl_shr   = 1'b0;
    ctl_read  = 1'b0;
    ctl_write = 1'b0;
    ctl_acc   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_NEXT;
      end
      S_FETCH: begin
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        ir_nx    = prog_data;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        arg      = ir[15:0];
        state_nx = S_NEXT;
        pc_nx    = pc_inc;
        unique case (op)
          OP_LDI: begin
            ctl_arg = 1'b1;
            ctl_acc = 1'b1;
          end
          OP_LD, OP_NAND: begin
            ctl_read = 1'b1;
            state_nx = S_MEM;
            pc_nx    = pc;
          end
          OP_ST: ctl_write = 1'b1;
          OP_SHL: begin
            ctl_shl = 1'b1;
            ctl_acc = 1'b1;
          end
          OP_SHR: begin
            ctl_shr = 1'b1;
            ctl_acc = 1'b1;
          end
          OP_JMP: pc_nx = tgt;
          OP_JZ: begin
            if (zf) pc_nx = tgt;
          end
          OP_JNZ: begin
            if (!zf) pc_nx = tgt;
          end
          OP_HALT: begin
            state_nx = S_HALT;
            pc_nx    = pc;
          end
          OP_NOP: ;
          default: ;
        endcase
      end
      S_MEM: begin
        arg      = ir[15:0];
        ctl_read = 1'b1;
        ctl_acc  = 1'b1;
        ctl_nad  = (op == OP_NAND);
        pc_nx    = pc_inc;
        state_nx = S_NEXT;
      end
      S_HALT: begin
        // pc keeps pointing at the HALT word until restarted
        if (start) begin
          pc_nx    = RST_PC;
          zf_nx    = 1'b0;
          state_nx = S_NEXT;
        end
      end
      S_WAIT: begin
`ifdef STEP_EN
        if (step) state_nx = S_FETCH;
`else
        state_nx = S_IDLE;
`endif
      end
      default: state_nx = S_IDLE;
    endcase

    if (ctl_acc) zf_nx = is_zero;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle vector table plus
// hand-written jump, wrap, flag and mid-instruction reset sequences.
module tb_control_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] prog_addr;
  logic [19:0]   prog_data;
  logic [15:0]   arg;
  logic          ctl_arg, ctl_nad, ctl_shl, ctl_shr;
  logic          ctl_read, ctl_write, ctl_acc;
  logic          is_zero, halted, busy;
`ifdef STEP_EN
  logic          step = 1'b1;
`endif

  int n_chk = 0;
  int n_fail = 0;

  control_sequencer #(.PROG_AW(AW), .RESET_PC(0)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef STEP_EN
    .step(step),
`endif
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .arg(arg),
    .ctl_arg(ctl_arg),
    .ctl_nad(ctl_nad),
    .ctl_shl(ctl_shl),
    .ctl_shr(ctl_shr),
    .ctl_read(ctl_read),
    .ctl_write(ctl_write),
    .ctl_acc(ctl_acc),
    .is_zero(is_zero),
    .halted(halted),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [19:0] rom [16];
  always @(posedge clk) prog_data <= rom[prog_addr];

  // small accumulator datapath
  logic [15:0] acc = 16'h0;
  logic [15:0] dmem [256];
  logic [15:0] mrd, alu;
  assign mrd = dmem[arg[7:0]];
  always_comb begin
    alu = 16'h0001;
    if (ctl_arg)       alu = arg;
    else if (ctl_nad)  alu = ~(acc & mrd);
    else if (ctl_shl)  alu = acc << 1;
    else if (ctl_shr)  alu = acc >> 1;
    else if (ctl_read) alu = mrd;
  end
  assign is_zero = (alu == 16'h0);
  always @(posedge clk) begin
    if (ctl_acc)   acc <= alu;
    if (ctl_write) dmem[arg[7:0]] <= acc;
  end

  logic [6:0] ctl;
  assign ctl = {ctl_arg, ctl_nad, ctl_shl, ctl_shr,
                ctl_read, ctl_write, ctl_acc};

  typedef struct {
    logic          start;
    logic [AW-1:0] addr;
    logic [15:0]   arg;
    logic [6:0]    ctl;
    logic          halted;
    logic          busy;
  } vec_t;

  vec_t v [21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 20'hF0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(string nm);
    int n = 0;
    while (!halted && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_halt"}, 32'(halted), 32'd1);
  endtask

  task automatic jump_case(string nm, logic [15:0] ldv,
                           logic [3:0] opj, logic [AW-1:0] exp_pc);
    clear_rom();
    rom[0] = {4'h1, ldv};
    rom[1] = {opj, 16'h0005};
    do_reset();
    start_run();
    wait_halt(nm);
    chk(nm, 32'(prog_addr), 32'(exp_pc));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0;
    clear_rom();
    rom[0] = 20'h11234;
    rom[1] = 20'h30010;
    rom[2] = 20'h20010;
    rom[3] = 20'h40010;
    rom[4] = 20'hF0000;

    v[0]  = '{1'b1, 4'h0, 16'h0000, 7'b0000000, 1'b0, 1'b0};
    v[1]  = '{1'b0, 4'h0, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[2]  = '{1'b0, 4'h0, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[3]  = '{1'b0, 4'h0, 16'h1234, 7'b1000001, 1'b0, 1'b1};
    v[4]  = '{1'b0, 4'h1, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[5]  = '{1'b0, 4'h1, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[6]  = '{1'b0, 4'h1, 16'h0010, 7'b0000010, 1'b0, 1'b1};
    v[7]  = '{1'b0, 4'h2, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[8]  = '{1'b0, 4'h2, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[9]  = '{1'b1, 4'h2, 16'h0010, 7'b0000100, 1'b0, 1'b1};
    v[10] = '{1'b0, 4'h2, 16'h0010, 7'b0000101, 1'b0, 1'b1};
    v[11] = '{1'b0, 4'h3, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[12] = '{1'b0, 4'h3, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[13] = '{1'b0, 4'h3, 16'h0010, 7'b0000100, 1'b0, 1'b1};
    v[14] = '{1'b0, 4'h3, 16'h0010, 7'b0100101, 1'b0, 1'b1};
    v[15] = '{1'b0, 4'h4, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[16] = '{1'b0, 4'h4, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[17] = '{1'b0, 4'h4, 16'h0000, 7'b0000000, 1'b0, 1'b1};
    v[18] = '{1'b0, 4'h4, 16'h0000, 7'b0000000, 1'b1, 1'b0};
    v[19] = '{1'b1, 4'h4, 16'h0000, 7'b0000000, 1'b1, 1'b0};
    v[20] = '{1'b0, 4'h0, 16'h0000, 7'b0000000, 1'b0, 1'b1};

    repeat (2) tick();
    reset = 1'b0;
    chk("reset_state", 32'({prog_addr, arg, ctl, halted, busy}), 32'd0);

    for (int i = 0; i < 21; i++) begin
      chk($sformatf("vec%0d", i),
          32'({prog_addr, arg, ctl, halted, busy}),
          32'({v[i].addr, v[i].arg, v[i].ctl, v[i].halted, v[i].busy}));
      start = v[i].start;
      tick();
    end
    start = 1'b0;
    chk("st_mem", 32'(dmem[16]), 32'h1234);
    chk("nand_acc", 32'(acc), 32'hEDCB);

    jump_case("jz_taken", 16'h0000, 4'h8, 4'd5);
    jump_case("jz_not", 16'h0001, 4'h8, 4'd2);
    jump_case("jnz_not", 16'h0000, 4'h9, 4'd2);
    jump_case("jnz_taken", 16'h0001, 4'h9, 4'd5);

    // restart from HALT must clear the flag set by the first pass
    clear_rom();
    rom[0] = 20'h80005;
    rom[1] = 20'h10000;
    do_reset();
    start_run();
    wait_halt("zf_run1");
    chk("zf_run1", 32'(prog_addr), 32'd2);
    start_run();
    wait_halt("zf_clr");
    chk("zf_clr", 32'(prog_addr), 32'd2);

    clear_rom();
    rom[0] = 20'h10000;
    rom[1] = 20'h30020;
    rom[2] = 20'h80005;
    do_reset();
    start_run();
    wait_halt("st_keeps_zf");
    chk("st_keeps_zf", 32'(prog_addr), 32'd5);

    clear_rom();
    rom[0] = 20'h18001;
    rom[1] = 20'h50000;
    rom[2] = 20'h60000;
    rom[3] = 20'h60000;
    rom[4] = 20'h80009;
    do_reset();
    start_run();
    wait_halt("shift");
    chk("shift_pc", 32'(prog_addr), 32'd9);
    chk("shift_acc", 32'(acc), 32'h0);

    clear_rom();
    rom[0]  = 20'h700FF;
    rom[15] = 20'h00000;
    do_reset();
    start_run();
    repeat (3) tick();
    chk("jmp_low_bits", 32'(prog_addr), 32'hF);
    repeat (3) tick();
    chk("pc_wrap", 32'(prog_addr), 32'h0);

    clear_rom();
    rom[0] = 20'h700F3;
    do_reset();
    start_run();
    wait_halt("jmp_f3");
    chk("jmp_f3", 32'(prog_addr), 32'd3);

    clear_rom();
    rom[0] = 20'hB1234;
    do_reset();
    start_run();
    repeat (2) tick();
    chk("opb_ctl", 32'(ctl), 32'd0);
    chk("opb_arg", 32'(arg), 32'h1234);
    wait_halt("opb");
    chk("opb_pc", 32'(prog_addr), 32'd1);

    clear_rom();
    rom[0] = 20'h40010;
    do_reset();
    start_run();
    repeat (3) tick();
    chk("nand_mem", 32'(ctl), 32'b0100101);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_mid", 32'({prog_addr, arg, ctl, halted, busy}), 32'd0);
    tick();
    chk("idle_hold", 32'({ctl, halted, busy}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
